// File: rtl/instr_fetch.sv
// Fetch stage: issues the PC to variable-latency instruction memory, buffers
// returned words with their PC and presents them to the decoder over valid/ready.
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [ADDR_W-1:0]  pc_addr_i,
    input  logic               flush_i,
    output logic               pc_stall_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]  pc_lat_q;
    logic [INSTR_W-1:0] word_q [DEPTH];
    logic [ADDR_W-1:0]  wpc_q  [DEPTH];

    logic pop_s;
    logic push_s;
    logic issue_s;

    assign instr_valid_o = (count_q != {CNT_W{1'b0}});
    assign instr_o       = word_q[rd_ptr_q];
    assign instr_pc_o    = wpc_q[rd_ptr_q];
    assign imem_req_o    = issue_s;
    assign imem_addr_o   = pc_addr_i;
    assign pc_stall_o    = !issue_s && !flush_i && !reset_i;

    // Handshake decode; a new request is only issued if its word is sure to
    // find a free slot, counting the word that lands this very cycle.
    always_comb begin
        pop_s   = instr_valid_o && instr_ready_i && !flush_i;
        push_s  = (state_q == S_WAIT) && imem_rvalid_i && !flush_i;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        issue_s = !reset_i && !flush_i && (count_d < DEPTH_C)
                  && ((state_q == S_IDLE) || push_s);
    end

    // Request FSM, output buffer storage and pointers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            count_q  <= {CNT_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            pc_lat_q <= {ADDR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= {INSTR_W{1'b0}};
                wpc_q[i]  <= {ADDR_W{1'b0}};
            end
        end else begin
            if (issue_s) begin
                pc_lat_q <= pc_addr_i;
            end
            if (flush_i) begin
                count_q  <= {CNT_W{1'b0}};
                rd_ptr_q <= {PTR_W{1'b0}};
                wr_ptr_q <= {PTR_W{1'b0}};
            end else begin
                count_q <= count_d;
                if (push_s) begin
                    word_q[wr_ptr_q] <= imem_rdata_i;
                    wpc_q[wr_ptr_q]  <= pc_lat_q;
                    wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    state_q <= issue_s ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= issue_s ? S_WAIT : S_IDLE;
                    end else if (flush_i) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    // The stale word is dropped; nothing is outstanding afterwards.
                    state_q <= imem_rvalid_i ? S_IDLE : S_DRAIN;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: acts as PC and instruction memory, and compares the
// DUT against a queue-based model of outstanding requests and buffered words.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  pc_addr_i;
    logic        flush_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_rvalid_i;
    logic [15:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [15:0] instr_o;
    logic [7:0]  instr_pc_o;

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pc_addr_i     (pc_addr_i),
        .flush_i       (flush_i),
        .pc_stall_o    (pc_stall_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus knobs
    bit         reset_v, flush_v, ready_v;
    logic [7:0] target_v;
    int         lat_min, lat_max;
    logic [7:0] pc;

    // memory model: one pending response plus a stale reply crossing reset
    bit          mem_pend, late_fire;
    int          mem_cnt;
    logic [15:0] mem_data;

    // reference model
    logic [23:0] q[$];
    bit          outst, stale, head_zero, seen_beef;
    logic [7:0]  lat_pc;
    bit          cap_want, cap_done;
    logic [7:0]  cap_addr;
    bit          found;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        rv;
        logic [15:0] rd;
        bit          got, push, pop, iss, exp_valid;
        int          sz;
        @(negedge clk_i);
        rv = 1'b0;
        rd = 16'h0000;
        if (late_fire && !reset_v) begin
            rv = 1'b1;
            rd = 16'hDEAD;
            late_fire = 1'b0;
        end else if (mem_pend) begin
            if (mem_cnt == 1) begin
                rv = 1'b1;
                rd = mem_data;
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        reset_i       = reset_v;
        flush_i       = flush_v;
        instr_ready_i = ready_v;
        pc_addr_i     = pc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #1;
        sz        = q.size();
        exp_valid = (sz > 0);
        got       = rv && outst;
        push      = got && !stale && !flush_v && !reset_v;
        pop       = exp_valid && ready_v && !flush_v;
        iss       = !reset_v && !flush_v && (!outst || push)
                    && (sz + int'(push) - int'(pop) < DEPTH);

        chk_val("imem_req", imem_req_o, iss);
        if (iss) chk_val("imem_addr", imem_addr_o, pc);
        chk_val("pc_stall", pc_stall_o, !iss && !flush_v && !reset_v);
        chk_val("instr_valid", instr_valid_o, exp_valid);
        if (exp_valid) begin
            chk_val("instr", instr_o, q[0][15:0]);
            chk_val("instr_pc", instr_pc_o, q[0][23:16]);
        end else if (head_zero) begin
            chk_val("instr_rst", instr_o, 32'h0);
            chk_val("instr_pc_rst", instr_pc_o, 32'h0);
        end
        if (instr_valid_o === 1'b1 && instr_o === 16'hBEEF) seen_beef = 1'b1;
        if (cap_want && imem_req_o === 1'b1) begin
            cap_addr = imem_addr_o;
            cap_want = 1'b0;
            cap_done = 1'b1;
        end

        if (reset_v) begin
            if (mem_pend) begin
                late_fire = 1'b1;
                mem_pend  = 1'b0;
            end
        end else if (iss) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(lat_max, lat_min);
            mem_data = 16'($urandom);
            if (mem_data == 16'hBEEF) mem_data = 16'hBEF0;
        end

        if (reset_v) begin
            q.delete();
            outst     = 1'b0;
            stale     = 1'b0;
            lat_pc    = 8'h00;
            head_zero = 1'b1;
        end else begin
            if (flush_v) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back({lat_pc, rd});
                    head_zero = 1'b0;
                end
            end
            if (got) begin
                outst = 1'b0;
                stale = 1'b0;
            end else if (flush_v && outst) begin
                stale = 1'b1;
            end
            if (iss) begin
                outst  = 1'b1;
                stale  = 1'b0;
                lat_pc = pc;
            end
        end

        if (reset_v)      pc = 8'h00;
        else if (flush_v) pc = target_v;
        else if (iss)     pc = pc + 8'd1;
    endtask

    initial begin
        reset_v = 1'b1; flush_v = 1'b0; ready_v = 1'b1; target_v = 8'h00;
        lat_min = 1; lat_max = 1; pc = 8'h00;
        mem_pend = 1'b0; late_fire = 1'b0; mem_cnt = 0; mem_data = 16'h0000;
        outst = 1'b0; stale = 1'b0; head_zero = 1'b1; seen_beef = 1'b0; lat_pc = 8'h00;
        cap_want = 1'b0; cap_done = 1'b0; cap_addr = 8'h00; found = 1'b0;
        reset_i = 1'b1; flush_i = 1'b0; instr_ready_i = 1'b1; pc_addr_i = 8'h00;
        imem_rvalid_i = 1'b0; imem_rdata_i = 16'h0000;

        // reset, then zero-wait memory with an always-ready decoder
        repeat (2) step();
        reset_v = 1'b0;
        repeat (10) step();

        // decoder stalled with 3-cycle memory: buffer fills, then drains
        ready_v = 1'b0; lat_min = 3; lat_max = 3;
        repeat (14) step();
        ready_v = 1'b1;
        repeat (10) step();

        // flush while waiting; the in-flight 16'hBEEF must be discarded
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (outst && !stale && mem_pend && mem_cnt == 3) begin
                found = 1'b1;
                break;
            end
        end
        chk_val("t3_sync", found, 1);
        mem_data = 16'hBEEF;
        flush_v = 1'b1; target_v = 8'h40; cap_want = 1'b1; cap_done = 1'b0;
        step();
        flush_v = 1'b0;
        repeat (12) step();
        chk_val("t3_beef_seen", seen_beef, 0);
        chk_val("t3_cap_done", cap_done, 1);
        chk_val("t3_first_addr", cap_addr, 8'h40);

        // flush coinciding with the returning word
        lat_min = 2; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (outst && !stale && mem_pend && mem_cnt == 1) begin
                found = 1'b1;
                break;
            end
        end
        chk_val("t4_sync", found, 1);
        flush_v = 1'b1; target_v = 8'h80;
        step();
        flush_v = 1'b0;
        repeat (8) step();

        // address wrap FF->00 with repeated fill/drain
        flush_v = 1'b1; target_v = 8'hFD; lat_min = 1; lat_max = 2;
        step();
        flush_v = 1'b0;
        for (int r = 0; r < 5; r++) begin
            ready_v = 1'b0;
            repeat (6) step();
            ready_v = 1'b1;
            repeat (6) step();
        end

        // reset while a request is outstanding; its reply arrives after reset
        lat_min = 4; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (outst && mem_pend && mem_cnt >= 2) begin
                found = 1'b1;
                break;
            end
        end
        chk_val("t6_sync", found, 1);
        reset_v = 1'b1;
        repeat (2) step();
        reset_v = 1'b0; cap_want = 1'b1; cap_done = 1'b0;
        repeat (8) step();
        chk_val("t6_cap_done", cap_done, 1);
        chk_val("t6_first_addr", cap_addr, 8'h00);

        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 2000; n++) begin
            reset_v  = ($urandom_range(199, 0) == 0);
            flush_v  = ($urandom_range(19, 0) == 0);
            ready_v  = ($urandom_range(9, 0) < 7);
            target_v = 8'($urandom);
            step();
        end
        reset_v = 1'b0; flush_v = 1'b0; ready_v = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
